// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Ping-pong reorder buffer placed after fft_core m_axis. Frames arrive in
// bit-reversed index order and leave in natural order, one frame per bank,
// at up to one sample per cycle.
//
// Optional feature macro: REORDER_TLAST_CHK_EN
//   defined     -> o_err_tlast port exists; sticky flag raised when
//                  s_axis_tlast disagrees with the counter-derived frame end.
//   not defined -> no o_err_tlast port; s_axis_tlast is ignored.
//
// Handshake semantics (both AXI4-Stream sides): a beat transfers on a rising
// clock edge where tvalid and tready are both high. A master holds tdata/tlast
// stable and keeps tvalid high until that transfer happens; tready may change
// freely and never depends on the same-cycle tvalid of this block's outputs.
module fft_bitrev_reorder #(
  parameter int DWIDTH        = 32,
  parameter int MAX_POINT     = 1024,
  parameter int MAX_POINT_LOG = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       i_point,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
`ifdef REORDER_TLAST_CHK_EN
  ,
  output logic              o_err_tlast
`endif
);

  localparam int AW = MAX_POINT_LOG;
  localparam int LW = $clog2(MAX_POINT_LOG + 1);

  // Read-side FSM state; kept as a named signal so checkers can bind to it.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  // ------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------

  // log2 of a legal frame length; anything else falls back to MAX_POINT.
  function automatic logic [LW-1:0] decode_log(input logic [10:0] pt);
    logic [LW-1:0] r;
    r = LW'(MAX_POINT_LOG);
    for (int l = 3; l <= MAX_POINT_LOG; l++) begin
      if (pt == 11'(1 << l)) r = LW'(l);
    end
    return r;
  endfunction

  // Index of the last beat of a frame of 2**lg points.
  function automatic logic [AW-1:0] last_idx(input logic [LW-1:0] lg);
    logic [AW:0] t;
    t = {{AW{1'b0}}, 1'b1} << lg;
    t = t - {{AW{1'b0}}, 1'b1};
    return t[AW-1:0];
  endfunction

  // Reverse the low lg bits of v (upper bits of v are zero by construction).
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v,
                                           input logic [LW-1:0] lg);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r >> (LW'(AW) - lg);
  endfunction

  // ------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     rd_cnt;
  logic [LW-1:0]     bank_log [2];

  logic [LW-1:0]     wr_log;
  logic [AW-1:0]     wr_addr;
  logic              wr_last;
  logic              s_fire;

  logic [LW-1:0]     rd_log;
  logic              rd_last;
  logic              rd_issue;
  logic              credit;

  rd_state_t         rd_state;
  rd_state_t         rd_state_nxt;

  logic [DWIDTH-1:0] mem [2*MAX_POINT];
  logic [DWIDTH-1:0] ram_q;
  logic              rd_pend;
  logic              rd_pend_last;

  logic [DWIDTH-1:0] skid_data [2];
  logic              skid_last [2];
  logic              skid_wptr;
  logic              skid_rptr;
  logic [1:0]        skid_cnt;
  logic              skid_push;
  logic              skid_pop;
  logic [2:0]        skid_occ;

  // ------------------------------------------------------------------
  // Write side
  // ------------------------------------------------------------------

  // Beat 0 uses the live i_point; later beats use the length latched at beat 0.
  always_comb begin
    wr_log  = (wr_cnt == '0) ? decode_log(i_point) : bank_log[wr_sel];
    wr_addr = bitrev(wr_cnt, wr_log);
    wr_last = (wr_cnt == last_idx(wr_log));
  end

  // Ready is held low while reset is asserted and whenever the write bank is occupied.
  assign s_axis_tready = !reset && !full[wr_sel];
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  // Write counter, bank select and per-bank frame length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt      <= '0;
      wr_sel      <= 1'b0;
      bank_log[0] <= LW'(MAX_POINT_LOG);
      bank_log[1] <= LW'(MAX_POINT_LOG);
    end else if (s_fire) begin
      if (wr_cnt == '0) bank_log[wr_sel] <= wr_log;
      if (wr_last) begin
        wr_cnt <= '0;
        wr_sel <= !wr_sel;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Bank-full flags: set by the last write, cleared by the last read issue.
  // The two never target the same bank in one cycle, so both may fire together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (s_fire && wr_last)   full[wr_sel] <= 1'b1;
      if (rd_issue && rd_last) full[rd_sel] <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Read side FSM
  // ------------------------------------------------------------------
  assign rd_log  = bank_log[rd_sel];
  assign rd_last = (rd_cnt == last_idx(rd_log));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_state_nxt;
  end

  // Next-state: leave IDLE on the first read; after the last read either chain
  // straight into the other bank or fall back to IDLE.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_issue) rd_state_nxt = RD_RUN;
      RD_RUN:  if (rd_issue && rd_last)
                 rd_state_nxt = full[!rd_sel] ? RD_RUN : RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Output decode: issue a RAM read whenever a frame is ready and the skid has room.
  always_comb begin
    rd_issue = 1'b0;
    case (rd_state)
      RD_IDLE: rd_issue = full[rd_sel] && credit;
      RD_RUN:  rd_issue = credit;
      default: rd_issue = 1'b0;
    endcase
  end

  // Read counter and read bank select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      rd_sel <= 1'b0;
    end else if (rd_issue) begin
      if (rd_last) begin
        rd_cnt <= '0;
        rd_sel <= !rd_sel;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Dual-bank RAM, synchronous read
  // ------------------------------------------------------------------

  // Storage: bank select is the address MSB.
  always_ff @(posedge clk) begin
    if (s_fire)   mem[{wr_sel, wr_addr}] <= s_axis_tdata;
    if (rd_issue) ram_q <= mem[{rd_sel, rd_cnt}];
  end

  // Tracks the read in flight through the RAM output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && rd_last;
    end
  end

  // ------------------------------------------------------------------
  // Two-entry output skid buffer
  // ------------------------------------------------------------------
  assign skid_push = rd_pend;
  assign skid_pop  = (skid_cnt != 2'd0) && m_axis_tready;

  // Occupancy after this cycle's pop, counting the read already in flight;
  // a new read may issue while that leaves at least one free slot.
  assign skid_occ = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, skid_pop};
  assign credit   = (skid_occ < 3'd2);

  // Skid storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data[0] <= '0;
      skid_data[1] <= '0;
      skid_last[0] <= 1'b0;
      skid_last[1] <= 1'b0;
      skid_wptr    <= 1'b0;
      skid_rptr    <= 1'b0;
      skid_cnt     <= 2'd0;
    end else begin
      if (skid_push) begin
        skid_data[skid_wptr] <= ram_q;
        skid_last[skid_wptr] <= rd_pend_last;
        skid_wptr            <= !skid_wptr;
      end
      if (skid_pop) skid_rptr <= !skid_rptr;
      case ({skid_push, skid_pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  assign m_axis_tvalid = (skid_cnt != 2'd0);
  assign m_axis_tdata  = skid_data[skid_rptr];
  assign m_axis_tlast  = skid_last[skid_rptr] && m_axis_tvalid;

  // ------------------------------------------------------------------
  // Optional tlast consistency check
  // ------------------------------------------------------------------
`ifdef REORDER_TLAST_CHK_EN
  // Sticky flag: tlast must be high exactly on the counter-derived last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               o_err_tlast <= 1'b0;
    else if (s_fire && (s_axis_tlast != wr_last)) o_err_tlast <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

endmodule
